phase_commutation_fsm: RTL and testbench

Per-output-phase four-step current-commutation controller for a 3x3 matrix converter. It receives a 2-bit input-phase selection and the output-current sign, and drives the six unidirectional switch gates (three bidirectional switches) of one output phase so that no switching sequence ever shorts two input phases or opens the inductive load path. The top level instantiates three copies, one per output phase; the short-protection gating that forces all gates off is outside this block.

---
 rtl/commutation_pkg.sv | 62 ++++++
 rtl/step_timer.sv | 39 +++
 rtl/phase_commutation_fsm.sv | 109 ++++++++++
 tb/tb_phase_commutation_fsm.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/commutation_pkg.sv
// Shared types and helpers for the matrix-converter output-phase commutation controller.
package commutation_pkg;

    localparam int unsigned GATE_W  = 6;
    localparam int unsigned PHASE_W = 2;

    localparam int unsigned A_FWD = 5;
    localparam int unsigned A_REV = 4;
    localparam int unsigned B_FWD = 3;
    localparam int unsigned B_REV = 2;
    localparam int unsigned C_FWD = 1;
    localparam int unsigned C_REV = 0;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_ON_A,
        ST_ON_B,
        ST_ON_C,
        ST_STEP1,
        ST_STEP2,
        ST_STEP3
    } state_e;

    typedef enum logic [PHASE_W-1:0] {
        PH_NONE = 2'b00,
        PH_A    = 2'b01,
        PH_B    = 2'b10,
        PH_C    = 2'b11
    } phase_e;

    // One-hot gate for the forward (fwd=1) or reverse (fwd=0) device of a phase.
    function automatic logic [GATE_W-1:0] gate_mask(phase_e ph, logic fwd);
        logic [GATE_W-1:0] m;
        m = '0;
        case (ph)
            PH_A: if (fwd) m[A_FWD] = 1'b1; else m[A_REV] = 1'b1;
            PH_B: if (fwd) m[B_FWD] = 1'b1; else m[B_REV] = 1'b1;
            PH_C: if (fwd) m[C_FWD] = 1'b1; else m[C_REV] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic state_e on_state(phase_e ph);
        case (ph)
            PH_A:    return ST_ON_A;
            PH_B:    return ST_ON_B;
            PH_C:    return ST_ON_C;
            default: return ST_OFF;
        endcase
    endfunction

    function automatic phase_e on_phase(state_e st);
        case (st)
            ST_ON_A: return PH_A;
            ST_ON_B: return PH_B;
            ST_ON_C: return PH_C;
            default: return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter; done_o is high during the last cycle of a STEP_CYCLES-long dwell.
module step_timer #(
    parameter int unsigned STEP_CYCLES = 55
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic done_o
);

    localparam int unsigned CNT_W = $clog2(STEP_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(STEP_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // done is registered from the next count so it lines up with cnt_q == 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= (cnt_d == CNT_W'(1));
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/phase_commutation_fsm.sv
// Four-step current commutation for one output phase of a 3x3 matrix converter.
module phase_commutation_fsm
    import commutation_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 55
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] DesiredLoad,
    input  logic               CURRSIGN,
    output logic [GATE_W-1:0]  Sout
);

    state_e             state_q, state_d;
    phase_e             src_q, src_d;
    phase_e             dst_q, dst_d;
    logic               sign_q, sign_d;
    logic [GATE_W-1:0]  sout_q, sout_d;
    logic               step_load;
    logic               step_done;
    phase_e             desired;
    phase_e             cur;

    step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (step_load),
        .done_o (step_done)
    );

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        sign_d    = sign_q;
        step_load = 1'b0;
        sout_d    = '0;
        desired   = phase_e'(DesiredLoad);
        cur       = on_phase(state_q);

        case (state_q)
            ST_OFF: begin
                if (desired != PH_NONE) begin
                    state_d = on_state(desired);
                end
            end
            ST_ON_A, ST_ON_B, ST_ON_C: begin
                sout_d = gate_mask(cur, 1'b1) | gate_mask(cur, 1'b0);
                // Source, target and current sign are frozen for the whole commutation.
                if (desired != cur) begin
                    src_d     = cur;
                    dst_d     = desired;
                    sign_d    = CURRSIGN;
                    state_d   = ST_STEP1;
                    step_load = 1'b1;
                end
            end
            ST_STEP1: begin
                sout_d = gate_mask(src_q, sign_q);
                if (step_done) begin
                    if (dst_q == PH_NONE) begin
                        state_d = ST_OFF;
                    end else begin
                        state_d   = ST_STEP2;
                        step_load = 1'b1;
                    end
                end
            end
            ST_STEP2: begin
                sout_d = gate_mask(src_q, sign_q) | gate_mask(dst_q, sign_q);
                if (step_done) begin
                    state_d   = ST_STEP3;
                    step_load = 1'b1;
                end
            end
            ST_STEP3: begin
                sout_d = gate_mask(dst_q, sign_q);
                if (step_done) begin
                    state_d = on_state(dst_q);
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // Gate drives follow the state register by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            src_q   <= PH_NONE;
            dst_q   <= PH_NONE;
            sign_q  <= 1'b0;
            sout_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            sign_q  <= sign_d;
            sout_q  <= sout_d;
        end
    end

    assign Sout = sout_q;

endmodule

// File: tb/tb_phase_commutation_fsm.sv
// Self-checking bench: table-driven vectors scored through a cycle-stamped expectation queue.
module tb_phase_commutation_fsm;

    localparam int unsigned STEP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dl;
    logic       cs;
    logic [5:0] sout;

    always #5 clk = ~clk;

    phase_commutation_fsm #(
        .STEP_CYCLES(STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .DesiredLoad (dl),
        .CURRSIGN    (cs),
        .Sout        (sout)
    );

    typedef struct {
        logic       r;
        logic [1:0] d;
        logic       c;
        logic [5:0] e;
        int         n;
        string      name;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [5:0] e;
        string      name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   ovl_en = 1'b0;

    // At most two devices on, and no forward/reverse pair across different phases.
    task automatic check_overlap();
        bit ok;
        ok = ($countones(sout) <= 2);
        for (int p = 0; p < 3; p++) begin
            for (int q = 0; q < 3; q++) begin
                if (p != q && sout[5 - 2*p] && sout[4 - 2*q]) ok = 1'b0;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL overlap cyc %0d Sout=%b violates gate-overlap rule", cyc, sout);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ovl_en) check_overlap();
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == cyc) begin
                checks++;
                if (sout !== sbq[i].e) begin
                    errors++;
                    $display("FAIL %s cyc %0d Sout=%b required %b", sbq[i].name, cyc, sout, sbq[i].e);
                end
                sbq.delete(i);
            end
        end
    endtask

    // Drive inputs for n cycles; each cycle's expectation is due two samples later.
    task automatic drive(input logic r, input logic [1:0] d, input logic c,
                         input logic [5:0] e, input int n, input string name);
        repeat (n) begin
            tick();
            rst = r;
            dl  = d;
            cs  = c;
            sbq.push_back('{cyc: cyc + 2, e: e, name: name});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached, %0d expectations pending", sbq.size());
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        dl  = 2'b00;
        cs  = 1'b1;

        vecs.push_back('{1'b1, 2'b01, 1'b1, 6'b000000, 3, "reset"});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 6'b110000, 3, "off_to_a"});
        // A -> B, positive current
        vecs.push_back('{1'b0, 2'b10, 1'b1, 6'b100000, 4, "ab_step1"});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 6'b101000, 4, "ab_step2"});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 6'b001000, 4, "ab_step3"});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 6'b001100, 3, "on_b"});
        // B -> A, negative current
        vecs.push_back('{1'b0, 2'b01, 1'b0, 6'b000100, 4, "ba_step1"});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 6'b010100, 4, "ba_step2"});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 6'b010000, 4, "ba_step3"});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 6'b110000, 3, "on_a"});
        // A -> C, negative current
        vecs.push_back('{1'b0, 2'b11, 1'b0, 6'b010000, 4, "ac_step1"});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 6'b010001, 4, "ac_step2"});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 6'b000001, 4, "ac_step3"});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 6'b000011, 3, "on_c"});
        // C -> B, positive current
        vecs.push_back('{1'b0, 2'b10, 1'b1, 6'b000010, 4, "cb_step1"});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 6'b001010, 4, "cb_step2"});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 6'b001000, 4, "cb_step3"});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 6'b001100, 3, "on_b2"});
        // B -> none, then back on A
        vecs.push_back('{1'b0, 2'b00, 1'b1, 6'b001000, 4, "bn_step1"});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 6'b000000, 3, "off"});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 6'b110000, 3, "off_to_a2"});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].d, vecs[i].c, vecs[i].e, vecs[i].n, vecs[i].name);
            if (i == 0) ovl_en = 1'b1;
        end

        // Request and sign changes during STEP2 are held off until B is steady.
        drive(1'b0, 2'b10, 1'b1, 6'b100000, 4, "late_step1");
        drive(1'b0, 2'b10, 1'b1, 6'b101000, 2, "late_step2a");
        drive(1'b0, 2'b11, 1'b0, 6'b101000, 2, "late_step2b");
        drive(1'b0, 2'b11, 1'b0, 6'b001000, 4, "late_step3");
        drive(1'b0, 2'b11, 1'b0, 6'b001100, 1, "late_on_b");
        drive(1'b0, 2'b11, 1'b0, 6'b000100, 4, "bc_step1");
        drive(1'b0, 2'b11, 1'b0, 6'b000101, 4, "bc_step2");
        drive(1'b0, 2'b11, 1'b0, 6'b000001, 4, "bc_step3");
        drive(1'b0, 2'b11, 1'b0, 6'b000011, 3, "on_c2");

        // Reset during STEP2 of C -> A forces all gates off on the next sample.
        drive(1'b0, 2'b01, 1'b1, 6'b000010, 4, "ca_step1");
        drive(1'b0, 2'b01, 1'b1, 6'b100010, 1, "ca_step2");
        drive(1'b0, 2'b01, 1'b1, 6'b000000, 1, "ca_aborted");
        drive(1'b1, 2'b01, 1'b1, 6'b000000, 1, "mid_reset");
        sbq.push_back('{cyc: cyc + 1, e: 6'b000000, name: "mid_reset_next"});
        drive(1'b1, 2'b01, 1'b1, 6'b000000, 1, "mid_reset_hold");
        drive(1'b0, 2'b00, 1'b1, 6'b000000, 3, "post_reset_off");
        drive(1'b0, 2'b10, 1'b0, 6'b001100, 3, "post_reset_on_b");

        repeat (3) tick();
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain %0d expectations left unchecked, required 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
